periph_uart: RTL

Memory-mapped 8N1 UART peripheral on the data bus's peripheral half (`data_addr_i[13]` = 1), decoded on the 13-bit offset the bus forwards. Receives single-cycle write/read requests, returns registered read data with `rvalid_o` one cycle later, and holds a TX FIFO, RX FIFO, baud generator and TX/RX bit-level state machines. Drives the device serial pins and a level interrupt.

---
 rtl/periph_uart_if.sv | 14 +
 rtl/periph_uart.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/periph_uart_if.sv
// Peripheral-bus port bundle for periph_uart: single-cycle request in,
// registered read response out.
interface periph_uart_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [12:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    modport master (output req_i, we_i, be_i, addr_i, wdata_i, input rvalid_o, rdata_o);
    modport slave  (input req_i, we_i, be_i, addr_i, wdata_i, output rvalid_o, rdata_o);
endinterface

// File: rtl/periph_uart.sv
// Memory-mapped 8N1 UART: CTRL/STATUS/TXDATA/RXDATA registers, TX and RX
// byte FIFOs, and bit-level TX/RX state machines sharing one divisor.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push, w_pop;

    assign full_o  = (r_cnt == (AW+1)'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign head_o  = r_mem[r_rp];
    // A push while full is dropped even when a pop frees a slot the same cycle.
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wp] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

module periph_uart #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    periph_uart_if.slave bus,
    input  logic         uart_rx_i,
    output logic         uart_tx_o,
    output logic         irq_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [15:0] r_div;
    logic        r_tx_en, r_rx_en, r_irq_en, r_ovr, r_ferr, r_rvalid, r_tx;
    logic [31:0] r_rdata;
    logic [1:0]  r_tx_st, r_rx_st;
    logic [15:0] r_tx_cnt, r_tx_div, r_rx_cnt, r_rx_div;
    logic [2:0]  r_tx_bit, r_rx_bit, r_sync;
    logic [7:0]  r_tx_sh, r_rx_sh;

    logic        w_sel, w_wr, w_rd, w_unused;
    logic [1:0]  w_reg;
    logic [15:0] w_div_eff, w_rx_half;
    logic [16:0] w_rx_p1;
    logic [7:0]  w_txf_head, w_rxf_head;
    logic        w_txf_full, w_txf_empty, w_rxf_full, w_rxf_empty;
    logic        w_tx_go, w_tx_tick, w_tx_pop, w_rx_tick, w_rx_bit, w_rx_fall;
    logic        w_rx_push, w_st_clr;
    logic [31:0] w_status, w_rmux;

    assign w_sel     = bus.req_i & (bus.addr_i[12:4] == 9'd0);
    assign w_reg     = bus.addr_i[3:2];
    assign w_wr      = w_sel & bus.we_i;
    assign w_rd      = w_sel & ~bus.we_i;
    assign w_div_eff = (r_div < 16'd3) ? 16'd3 : r_div;
    assign w_st_clr  = w_wr & (w_reg == 2'd1) & bus.be_i[0];
    assign w_unused  = ^{bus.addr_i[1:0], bus.wdata_i[31:19], bus.be_i[3], w_rx_p1[0]};

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_txf (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .push_i(w_wr & (w_reg == 2'd2) & bus.be_i[0]), .pop_i(w_tx_pop),
        .data_i(bus.wdata_i[7:0]), .head_o(w_txf_head),
        .full_o(w_txf_full), .empty_o(w_txf_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rxf (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .push_i(w_rx_push), .pop_i(w_rd & (w_reg == 2'd3)),
        .data_i(r_rx_sh), .head_o(w_rxf_head),
        .full_o(w_rxf_full), .empty_o(w_rxf_empty)
    );

    // TX: a new frame may start from IDLE or directly at the end of a stop bit.
    assign w_tx_go   = ~w_txf_empty & r_tx_en;
    assign w_tx_tick = (r_tx_cnt == r_tx_div);
    assign w_tx_pop  = w_tx_go & ((r_tx_st == S_IDLE) | ((r_tx_st == S_STOP) & w_tx_tick));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_st  <= S_IDLE;
            r_tx_cnt <= '0;
            r_tx_div <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_tx     <= 1'b1;
        end else if (w_tx_pop) begin
            r_tx_st  <= S_START;
            r_tx_cnt <= '0;
            r_tx_div <= w_div_eff;
            r_tx_sh  <= w_txf_head;
            r_tx     <= 1'b0;
        end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
            case (r_tx_st)
                S_START: if (w_tx_tick) begin
                    r_tx_st  <= S_DATA;
                    r_tx_cnt <= '0;
                    r_tx_bit <= '0;
                    r_tx     <= r_tx_sh[0];
                    r_tx_sh  <= r_tx_sh >> 1;
                end
                S_DATA: if (w_tx_tick) begin
                    r_tx_cnt <= '0;
                    r_tx_bit <= r_tx_bit + 3'd1;
                    r_tx_sh  <= r_tx_sh >> 1;
                    r_tx     <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_sh[0];
                    if (r_tx_bit == 3'd7) r_tx_st <= S_STOP;
                end
                S_STOP: if (w_tx_tick) begin
                    r_tx_st  <= S_IDLE;
                    r_tx_cnt <= '0;
                end
                default: r_tx_cnt <= '0;
            endcase
        end
    end

    // RX: r_sync[1] is the synchronised line; r_sync[2] only serves edge detect.
    assign w_rx_bit  = r_sync[1];
    assign w_rx_fall = r_sync[2] & ~r_sync[1];
    assign w_rx_tick = (r_rx_cnt == r_rx_div);
    assign w_rx_p1   = {1'b0, r_rx_div} + 17'd1;
    assign w_rx_half = w_rx_p1[16:1];
    assign w_rx_push = r_rx_en & (r_rx_st == S_STOP) & w_rx_tick;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync   <= 3'b111;
            r_rx_st  <= S_IDLE;
            r_rx_cnt <= '0;
            r_rx_div <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
        end else begin
            r_sync   <= {r_sync[1:0], uart_rx_i};
            r_rx_cnt <= r_rx_cnt + 16'd1;
            if (!r_rx_en) begin
                r_rx_st  <= S_IDLE;
                r_rx_cnt <= '0;
            end else begin
                case (r_rx_st)
                    S_IDLE: begin
                        // The edge is seen one cycle late, so the count starts at 1.
                        r_rx_cnt <= 16'd1;
                        if (w_rx_fall) begin
                            r_rx_st  <= S_START;
                            r_rx_div <= w_div_eff;
                        end
                    end
                    S_START: if (r_rx_cnt == w_rx_half) begin
                        r_rx_st  <= w_rx_bit ? S_IDLE : S_DATA;
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                    end
                    S_DATA: if (w_rx_tick) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {w_rx_bit, r_rx_sh[7:1]};
                        r_rx_bit <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_st <= S_STOP;
                    end
                    default: if (w_rx_tick) r_rx_st <= S_IDLE;
                endcase
            end
        end
    end

    assign w_status = {25'd0, (r_tx_st != S_IDLE), r_ferr, r_ovr,
                       w_rxf_empty, w_rxf_full, w_txf_empty, w_txf_full};

    always_comb begin
        w_rmux = '0;
        case (w_reg)
            2'd0:    w_rmux = {13'd0, r_irq_en, r_rx_en, r_tx_en, r_div};
            2'd1:    w_rmux = w_status;
            2'd3:    w_rmux = w_rxf_empty ? 32'd0 : {24'd0, w_rxf_head};
            default: w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div    <= DIV_RESET;
            r_tx_en  <= 1'b0;
            r_rx_en  <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovr    <= 1'b0;
            r_ferr   <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_wr && w_reg == 2'd0) begin
                if (bus.be_i[0]) r_div[7:0]  <= bus.wdata_i[7:0];
                if (bus.be_i[1]) r_div[15:8] <= bus.wdata_i[15:8];
                if (bus.be_i[2]) {r_irq_en, r_rx_en, r_tx_en} <= bus.wdata_i[18:16];
            end
            // Set events beat a same-cycle write-1-to-clear.
            r_ovr  <= (w_rx_push & w_rxf_full) | (r_ovr & ~(w_st_clr & bus.wdata_i[4]));
            r_ferr <= (w_rx_push & ~w_rx_bit) | (r_ferr & ~(w_st_clr & bus.wdata_i[5]));
            r_rvalid <= bus.req_i & ~bus.we_i;
            if (bus.req_i && !bus.we_i) r_rdata <= w_sel ? w_rmux : 32'd0;
        end
    end

    assign bus.rvalid_o = r_rvalid;
    assign bus.rdata_o  = r_rdata;
    assign uart_tx_o    = r_tx;
    assign irq_o        = r_irq_en & ~w_rxf_empty;
endmodule
